// File: rtl/rv32i_inst_prefetch_if.sv
// Bus bundle between the instruction prefetch queue, instruction memory and fetch.
// The master modport is the prefetcher; the slave side is memory plus fetch.
interface rv32i_inst_prefetch_if;
    logic        o_req;
    logic [31:0] o_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    modport master (
        output o_req, o_req_addr, o_valid, o_inst, o_pc,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_ready, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_req, o_req_addr, o_valid, o_inst, o_pc,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/rv32i_inst_prefetch.sv
// Instruction prefetch queue: credit-limited sequential word requests, PC-tagged
// response FIFO toward fetch, and redirect flush that discards old-path responses.
module rv32i_inst_prefetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rv32i_inst_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic [CW:0]   credit_sum_s;
    logic [31:0]   redirect_pc_s;
    logic          req_s;
    logic          accept_s;
    logic          rsp_s;
    logic          valid_s;
    logic          pop_s;
    logic          push_s;

    // Handshake decode; everything here depends only on registered state and inputs.
    always_comb begin
        credit_sum_s  = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
        req_s         = !i_rst && (credit_sum_s < DEPTH_W);
        accept_s      = req_s && bus.i_req_ready;
        // A response with nothing outstanding is illegal and simply ignored.
        rsp_s         = bus.i_rsp_valid && (outstanding_q != {CW{1'b0}});
        valid_s       = !i_rst && (fifo_count_q != {CW{1'b0}});
        pop_s         = valid_s && bus.i_ready && !bus.i_redirect;
        push_s        = rsp_s && (discard_q == {CW{1'b0}}) && !bus.i_redirect;
        redirect_pc_s = bus.i_redirect_pc & 32'hFFFF_FFFC;
    end

    // Next-state for PCs, credit counters and FIFO pointers.
    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        fifo_count_d  = fifo_count_q;
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        outstanding_d = outstanding_q + CW'(accept_s) - CW'(rsp_s);

        if (bus.i_redirect) begin
            // Everything still in flight after this edge belongs to the old path,
            // including a request accepted in this very cycle.
            req_pc_d     = redirect_pc_s;
            rsp_pc_d     = redirect_pc_s;
            discard_d    = outstanding_d;
            fifo_count_d = {CW{1'b0}};
            head_d       = {PW{1'b0}};
            tail_d       = {PW{1'b0}};
        end else begin
            if (accept_s) begin
                req_pc_d = req_pc_q + 32'd4;
            end else begin
                req_pc_d = req_pc_q;
            end
            if (rsp_s && (discard_q != {CW{1'b0}})) begin
                discard_d = discard_q - CW'(1'b1);
            end else begin
                discard_d = discard_q;
            end
            if (push_s) begin
                tail_d   = tail_q + PW'(1'b1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end else begin
                tail_d   = tail_q;
                rsp_pc_d = rsp_pc_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1'b1);
            end else begin
                head_d = head_q;
            end
            fifo_count_d = fifo_count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_pc_q      <= PC_RESET;
            rsp_pc_q      <= PC_RESET;
            fifo_count_q  <= {CW{1'b0}};
            outstanding_q <= {CW{1'b0}};
            discard_q     <= {CW{1'b0}};
            head_q        <= {PW{1'b0}};
            tail_q        <= {PW{1'b0}};
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            fifo_count_q  <= fifo_count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    // FIFO storage; contents are don't-care until counted valid, so no reset.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_inst_q[tail_q] <= bus.i_rsp_data;
            fifo_pc_q[tail_q]   <= rsp_pc_q;
        end
    end

    assign bus.o_req      = req_s;
    assign bus.o_req_addr = req_pc_q;
    assign bus.o_valid    = valid_s;
    assign bus.o_inst     = valid_s ? fifo_inst_q[head_q] : 32'h0000_0000;
    assign bus.o_pc       = valid_s ? fifo_pc_q[head_q]   : 32'h0000_0000;
endmodule

// File: doc/rv32i_inst_prefetch.md
# rv32i_inst_prefetch

Instruction prefetch queue upstream of the fetch stage. Issues sequential word requests to instruction memory and tracks outstanding requests with credit-based flow control. In-order responses are buffered in a small FIFO, each tagged with its PC, and presented to fetch with a valid/ready handshake. A PC redirect from a branch or trap flushes the queue and discards responses still in flight for the old path.

## Interface
- PC_RESET, 32'h0000_0000, address of first request after reset
- DEPTH, 4, FIFO entries and maximum in-flight requests (power of 2, ≥2)

- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- o_req  out  1  memory request valid
- o_req_addr  out  32  word address of request, bits[1:0] always 0
- i_req_ready  in  1  memory accepts request this cycle (accept = o_req & i_req_ready)
- i_rsp_valid  in  1  response data valid (in order, latency ≥1 cycle after accept)
- i_rsp_data  in  32  instruction word
- o_valid  out  1  FIFO head valid
- o_inst  out  32  head instruction, 0 when o_valid=0
- o_pc  out  32  head PC, 0 when o_valid=0
- i_ready  in  1  fetch consumes head (pop = o_valid & i_ready)
- i_redirect  in  1  flush queue, restart at i_redirect_pc
- i_redirect_pc  in  32  new PC, bits[1:0] ignored (treated as 0)

## Operation
- State: req_pc, rsp_pc (PC of next kept response), fifo_count, outstanding, discard (counters clog2(DEPTH)+1 bits), FIFO storage {inst, pc}.
- o_req = !i_rst && (fifo_count + outstanding < DEPTH); o_req_addr = req_pc.
- Accept: req_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0), outstanding += 1.
- Response: outstanding -= 1; if discard > 0, drop it and discard -= 1; else push {i_rsp_data, rsp_pc}, rsp_pc += 4.
- Simultaneous accept and response in one cycle: outstanding unchanged.
- Pop: head advances, fifo_count -= 1. Push and pop in the same cycle are allowed. Credit rule guarantees no push when full.
- Redirect (priority over pop/push):
  - FIFO cleared; pop and any response in that cycle are ignored.
  - req_pc = rsp_pc = {i_redirect_pc[31:2], 2'b00}.
  - discard = outstanding + accept − rsp_valid, the number still in flight after the edge. A request accepted in the redirect cycle carries the old address and is discarded.
  - outstanding is updated normally.
- i_rsp_valid with outstanding = 0 is illegal. It is ignored and flagged by bench assertion.
- Sustained 1 instr/cycle requires DEPTH ≥ L+1 for memory latency L.

## Timing
- Reset (sync, i_rst=1 at edge):
  - req_pc=PC_RESET, rsp_pc=PC_RESET, all counters 0, FIFO empty.
  - During the reset cycle and the cycle after: o_req=0 while i_rst=1; o_valid=0, o_inst=0, o_pc=0.
- First request: o_req=1 in the first cycle after i_rst deasserts, addr=PC_RESET.
- Request accepted at cycle N, response at N+L: entry visible (o_valid=1) at N+L+1.
- No combinational path from i_rsp_* to o_valid/o_inst/o_pc.
- o_req depends only on registered state (and i_rst), not on i_req_ready.
- Redirect asserted at cycle R:
  - o_valid=0 at R+1.
  - o_req_addr=redirect_pc at R+1 (if credit allows).
  - First new-path instruction no earlier than R+1+L+1, after all discards drain.
- Reset mid-operation: in-flight responses after reset are not tracked. The memory must be reset together with this block.

## Test plan
- Reset, PC_RESET=0x100, L=1, i_ready=1 → addresses 0x100,0x104,0x108…; o_valid from cycle 3 with o_pc 0x100,0x104… one per cycle, no gaps with DEPTH=4.
- i_ready=0 held → exactly 4 requests issued, o_req drops, FIFO holds 0x100–0x10C. Raise i_ready → in-order drain, requests resume as credits free.
- L=3, two requests in flight, redirect to 0x2002 → both old responses dropped; next o_pc=0x2000, then 0x2004; no stale entry ever visible.
- Redirect in the same cycle as an accept and a response → discard count correct (old accept dropped); o_pc sequence restarts cleanly at redirect target.
- req_pc starting at 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 with matching o_pc.
- Random i_req_ready/i_ready/latency 1–4 with redirects; scoreboard checks o_inst = mem[o_pc] and PC order; fifo_count + outstanding ≤ DEPTH always.
